// File: rtl/enigma_pkg.sv
// enigma_pkg: shared alphabet constants, letter type, stepper FSM states and mod-26 helpers.
package enigma_pkg;
  localparam int ALPHABET = 26;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_a = 8'h61;
  typedef logic [4:0] letter_t;
  typedef enum logic [1:0] {IDLE, STEP, ISSUE, WAIT} state_t;
  function automatic letter_t inc26(letter_t v);
    return (v == letter_t'(ALPHABET - 1)) ? '0 : v + 1'b1;
  endfunction
  function automatic letter_t fold26(letter_t v);
    return (v > letter_t'(ALPHABET - 1)) ? v - letter_t'(ALPHABET) : v;
  endfunction
endpackage

// File: rtl/enigma_plugboard.sv
// enigma_plugboard: 26-entry programmable letter map; entries above 25 pass the letter through.
module enigma_plugboard import enigma_pkg::*; (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    set,
  input  logic [8*ALPHABET-1:0]   plug_in,
  input  letter_t                 idx,
  output letter_t                 map_idx
);
  logic [7:0] tbl_q [ALPHABET];
  logic [7:0] tbl_d [ALPHABET];
  always_comb begin
    for (int i = 0; i < ALPHABET; i++) tbl_d[i] = set ? plug_in[8*i +: 8] : tbl_q[i];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ALPHABET; i++) tbl_q[i] <= 8'(i);
    end else begin
      tbl_q <= tbl_d;
    end
  end
  assign map_idx = (tbl_q[idx] > 8'd25) ? idx : tbl_q[idx][4:0];
endmodule

// File: rtl/enigma_stepper.sv
// enigma_stepper: ASCII intake, case fold, plugboard and 3-rotor stepping ahead of the rotor chain.
// Define DOUBLE_STEP_EN for the historical middle-rotor double step.
module enigma_stepper import enigma_pkg::*; #(
  parameter int DEF_NOTCH0   = 16,
  parameter int DEF_NOTCH1   = 4,
  parameter int DEF_NOTCH2   = 21,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set,
  input  logic [14:0]           cfg_pos,
  input  logic [14:0]           cfg_notch,
  input  logic [8*ALPHABET-1:0] plug_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            din,
  output logic                  out_valid,
  output logic [7:0]            out_idx,
  output logic [2:0]            rot,
  input  logic                  chain_done,
  output logic [14:0]           pos,
  output logic                  err
);
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  state_t state_q, state_d;
  letter_t idx_q, idx_d, map_idx, lt, p0, p1, p2, n0, n1;
  logic [14:0] pos_q, pos_d;
  logic [9:0] notch_q, notch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, is_up, is_lo, is_letter, timeout, unused_n2;
  logic [2:0] rot_c;
  // The slow rotor's notch never carries anywhere; it is accepted but has no effect.
  assign unused_n2 = ^{cfg_notch[14:10], 5'(DEF_NOTCH2)};
  assign {p2, p1, p0} = pos_q;
  assign {n1, n0} = notch_q;
  assign is_up = din >= ASCII_A && din <= ASCII_A + 8'd25;
  assign is_lo = din >= ASCII_a && din <= ASCII_a + 8'd25;
  assign is_letter = is_up || is_lo;
  assign lt = is_up ? letter_t'(din - ASCII_A) : letter_t'(din - ASCII_a);
  assign timeout = cnt_q == CW'(WAIT_TIMEOUT - 1);
`ifdef DOUBLE_STEP_EN
  assign rot_c = {p1 == n1, (p0 == n0) || (p1 == n1), 1'b1};
`else
  assign rot_c = {p1 == n1, p0 == n0, 1'b1};
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pos_d = pos_q;
    notch_d = notch_q;
    cnt_d = '0;
    err_d = 1'b0;
    if (set) begin
      state_d = IDLE;
      pos_d = {fold26(cfg_pos[14:10]), fold26(cfg_pos[9:5]), fold26(cfg_pos[4:0])};
      notch_d = cfg_notch[9:0];
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_d = is_letter ? STEP : IDLE;
          idx_d = is_letter ? lt : idx_q;
          err_d = !is_letter;
        end
        STEP: begin
          state_d = ISSUE;
          pos_d = {rot_c[2] ? inc26(p2) : p2, rot_c[1] ? inc26(p1) : p1, inc26(p0)};
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          state_d = (chain_done || timeout) ? IDLE : WAIT;
          err_d = !chain_done && timeout;
          cnt_d = cnt_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      pos_q <= '0;
      notch_q <= {5'(DEF_NOTCH1), 5'(DEF_NOTCH0)};
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pos_q <= pos_d;
      notch_q <= notch_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  enigma_plugboard u_plug (
    .clk(clk),
    .reset_n(reset_n),
    .set(set),
    .plug_in(plug_in),
    .idx(idx_q),
    .map_idx(map_idx)
  );
  assign in_ready = (state_q == IDLE) && !set;
  assign out_valid = (state_q == ISSUE) && !set;
  assign rot = (state_q == STEP && !set) ? rot_c : 3'b000;
  assign out_idx = out_valid ? {3'b000, map_idx} : 8'd0;
  assign pos = pos_q;
  assign err = err_q;
endmodule

// File: tb/tb_enigma_stepper.sv
// tb_enigma_stepper: table-driven character vectors plus timeout, set-abort and reset sequences.
module tb_enigma_stepper;
  logic clk = 1'b0, reset_n = 1'b0, set = 1'b0, in_valid = 1'b0, chain_done = 1'b0;
  logic [14:0] cfg_pos = '0, cfg_notch = '0;
  logic [207:0] plug_in, ident_tbl, swap_tbl;
  logic [7:0] din = '0, out_idx;
  logic in_ready, out_valid, err;
  logic [2:0] rot;
  logic [14:0] pos;
  int pass_cnt = 0, tot = 0;
  always #5 clk = ~clk;
  enigma_stepper dut (
    .clk(clk), .reset_n(reset_n), .set(set), .cfg_pos(cfg_pos), .cfg_notch(cfg_notch),
    .plug_in(plug_in), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_idx(out_idx), .rot(rot), .chain_done(chain_done),
    .pos(pos), .err(err)
  );
  typedef struct {
    bit do_set;
    logic [14:0] cpos;
    logic [14:0] cnotch;
    bit swap;
    logic [14:0] s_pos;
    logic [7:0] c;
    bit letter;
    logic [7:0] e_idx;
    logic [2:0] e_rot;
    logic [14:0] e_pos;
  } vec_t;
  vec_t v[18];
  function automatic logic [14:0] p(int a2, int a1, int a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic do_set(input logic [14:0] cp, input logic [14:0] cn, input bit sw, input logic [14:0] ep);
    cfg_pos = cp;
    cfg_notch = cn;
    plug_in = sw ? swap_tbl : ident_tbl;
    set = 1'b1;
    #1;
    chk("set_ready", in_ready, 0);
    chk("set_rot", rot, 0);
    chk("set_valid", out_valid, 0);
    @(posedge clk); #1;
    set = 1'b0;
    #1;
    chk("set_pos", pos, ep);
    chk("set_idle", in_ready, 1);
  endtask
  task automatic send(input logic [7:0] c, input bit letter, input logic [7:0] ei,
                      input logic [2:0] er, input logic [14:0] ep, input bit ack);
    chk($sformatf("pre_ready '%c'", c), in_ready, 1);
    din = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!letter) begin
      chk($sformatf("drop_err '%c'", c), err, 1);
      chk($sformatf("drop_valid '%c'", c), out_valid, 0);
      chk($sformatf("drop_rot '%c'", c), rot, 0);
      chk($sformatf("drop_pos '%c'", c), pos, ep);
      chk($sformatf("drop_ready '%c'", c), in_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("drop_err_clr '%c'", c), err, 0);
      chk($sformatf("drop_noissue '%c'", c), out_valid, 0);
    end else begin
      chk($sformatf("rot '%c'", c), rot, er);
      chk($sformatf("early_valid '%c'", c), out_valid, 0);
      chk($sformatf("busy '%c'", c), in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("out_valid '%c'", c), out_valid, 1);
      chk($sformatf("out_idx '%c'", c), out_idx, ei);
      chk($sformatf("pos '%c'", c), pos, ep);
      chk($sformatf("rot_clr '%c'", c), rot, 0);
      if (ack) begin
        chain_done = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("wait_busy '%c'", c), in_ready, 0);
        @(posedge clk); #1;
        chain_done = 1'b0;
        chk($sformatf("done_idle '%c'", c), in_ready, 1);
        chk($sformatf("valid_clr '%c'", c), out_valid, 0);
        chk($sformatf("err_idle '%c'", c), err, 0);
      end
    end
  endtask
  initial begin
    int n;
    for (int i = 0; i < 26; i++) ident_tbl[8*i +: 8] = 8'(i);
    swap_tbl = ident_tbl;
    swap_tbl[0 +: 8] = 8'd25;
    swap_tbl[200 +: 8] = 8'd0;
    swap_tbl[8 +: 8] = 8'd200;
    swap_tbl[16 +: 8] = 8'd7;
    plug_in = ident_tbl;
    v[0]  = '{0, 0, 0, 0, 0, "A", 1, 0, 3'b001, p(0, 0, 1)};
    v[1]  = '{0, 0, 0, 0, 0, "z", 1, 25, 3'b001, p(0, 0, 2)};
    v[2]  = '{0, 0, 0, 0, 0, "5", 0, 0, 0, p(0, 0, 2)};
    v[3]  = '{0, 0, 0, 0, 0, "@", 0, 0, 0, p(0, 0, 2)};
    v[4]  = '{0, 0, 0, 0, 0, "[", 0, 0, 0, p(0, 0, 2)};
    v[5]  = '{0, 0, 0, 0, 0, 8'h60, 0, 0, 0, p(0, 0, 2)};
    v[6]  = '{0, 0, 0, 0, 0, "{", 0, 0, 0, p(0, 0, 2)};
    v[7]  = '{0, 0, 0, 0, 0, "m", 1, 12, 3'b001, p(0, 0, 3)};
    v[8]  = '{1, p(0, 0, 16), p(21, 4, 16), 0, p(0, 0, 16), "a", 1, 0, 3'b011, p(0, 1, 17)};
    v[9]  = '{1, p(0, 3, 20), p(21, 4, 21), 0, p(0, 3, 20), "b", 1, 1, 3'b001, p(0, 3, 21)};
    v[10] = '{0, 0, 0, 0, 0, "c", 1, 2, 3'b011, p(0, 4, 22)};
`ifdef DOUBLE_STEP_EN
    v[11] = '{0, 0, 0, 0, 0, "d", 1, 3, 3'b111, p(1, 5, 23)};
`else
    v[11] = '{0, 0, 0, 0, 0, "d", 1, 3, 3'b101, p(1, 4, 23)};
`endif
    v[12] = '{1, p(25, 25, 25), p(0, 25, 25), 1, p(25, 25, 25), "Z", 1, 0, 3'b111, p(0, 0, 0)};
    v[13] = '{0, 0, 0, 0, 0, "a", 1, 25, 3'b001, p(0, 0, 1)};
    v[14] = '{0, 0, 0, 0, 0, "B", 1, 1, 3'b001, p(0, 0, 2)};
    v[15] = '{0, 0, 0, 0, 0, "c", 1, 7, 3'b001, p(0, 0, 3)};
    v[16] = '{1, p(31, 27, 26), p(21, 4, 16), 0, p(5, 1, 0), "Y", 1, 24, 3'b001, p(5, 1, 1)};
    v[17] = '{0, 0, 0, 0, 0, "5", 0, 0, 0, p(5, 1, 1)};
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_rot", rot, 0);
    chk("rst_err", err, 0);
    chk("rst_pos", pos, 0);
    for (int i = 0; i < 18; i++) begin
      if (v[i].do_set) do_set(v[i].cpos, v[i].cnotch, v[i].swap, v[i].s_pos);
      send(v[i].c, v[i].letter, v[i].e_idx, v[i].e_rot, v[i].e_pos, 1'b1);
    end
    send("A", 1, 0, 3'b001, p(5, 1, 2), 1'b0);
    n = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk); #1;
      if (in_ready) begin
        n = k;
        break;
      end
    end
    chk("timeout_cycles", n, 1025);
    chk("timeout_err", err, 1);
    chk("timeout_pos", pos, p(5, 1, 2));
    @(posedge clk); #1;
    chk("timeout_err_clr", err, 0);
    send("B", 1, 1, 3'b001, p(5, 1, 3), 1'b0);
    @(posedge clk); #1;
    chk("wait_ready", in_ready, 0);
    do_set(p(2, 3, 4), p(21, 4, 16), 1, p(2, 3, 4));
    chain_done = 1'b1;
    #1;
    chk("late_done_ready", in_ready, 1);
    @(posedge clk); #1;
    chain_done = 1'b0;
    chk("late_done_idle", in_ready, 1);
    chk("late_done_valid", out_valid, 0);
    send("A", 1, 25, 3'b001, p(2, 3, 5), 1'b1);
    din = "C";
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_set(p(7, 8, 9), p(21, 4, 16), 1, p(7, 8, 9));
    send("A", 1, 25, 3'b001, p(7, 8, 10), 1'b1);
    din = "D";
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_rot", rot, 0);
    chk("mid_rst_valid", out_valid, 0);
    send("A", 1, 0, 3'b001, p(0, 0, 1), 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
